// File: rtl/cabac_mvd_top_ctrl_pkg.sv
// Shared widths, state encodings and address helper for the CABAC top-neighbour MVD sequencer.
package cabac_mvd_top_ctrl_pkg;
  localparam int FMV_WIDTH       = 8;
  localparam int ADDR_W          = 9;
  localparam int IDX_W           = 4;
  localparam int DATA_W          = 2 * (FMV_WIDTH + 1);
  localparam int LCU_X_W         = ADDR_W - IDX_W;
  localparam int MVD_TOP_ENTRIES = 16;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MVD_TOP_ENTRIES - 1);

  typedef enum logic [1:0] {
    MVD_TOP_IDLE     = 2'd0,
    MVD_TOP_PREFETCH = 2'd1,
    MVD_TOP_READY    = 2'd2,
    MVD_TOP_WB       = 2'd3
  } mvd_top_state_t;

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [LCU_X_W-1:0] x,
                                                 input logic [IDX_W-1:0]   idx);
    return {x, idx};
  endfunction
endpackage

// File: rtl/cabac_mvd_top_ctrl_if.sv
// Bundle between the CABAC syntax/context side, the MVD line memory and the sequencer.
interface cabac_mvd_top_ctrl_if;
  import cabac_mvd_top_ctrl_pkg::*;

  logic               lcu_start_i;
  logic [LCU_X_W-1:0] lcu_x_i;
  logic               first_row_i;
  logic               lcu_done_i;
  logic [IDX_W-1:0]   rd_idx_i;
  logic [DATA_W-1:0]  rd_data_o;
  logic               upd_valid_i;
  logic [IDX_W-1:0]   upd_idx_i;
  logic [DATA_W-1:0]  upd_data_i;
  logic               prefetch_done_o;
  logic               wb_done_o;
  logic               busy_o;
  logic               err_o;
  logic               mem_r_en_o;
  logic [ADDR_W-1:0]  mem_r_addr_o;
  logic [DATA_W-1:0]  mem_r_data_i;
  logic               mem_w_en_o;
  logic [ADDR_W-1:0]  mem_w_addr_o;
  logic [DATA_W-1:0]  mem_w_data_o;

  modport master (
    output lcu_start_i, lcu_x_i, first_row_i, lcu_done_i, rd_idx_i,
    output upd_valid_i, upd_idx_i, upd_data_i, mem_r_data_i,
    input  rd_data_o, prefetch_done_o, wb_done_o, busy_o, err_o,
    input  mem_r_en_o, mem_r_addr_o, mem_w_en_o, mem_w_addr_o, mem_w_data_o
  );

  modport slave (
    input  lcu_start_i, lcu_x_i, first_row_i, lcu_done_i, rd_idx_i,
    input  upd_valid_i, upd_idx_i, upd_data_i, mem_r_data_i,
    output rd_data_o, prefetch_done_o, wb_done_o, busy_o, err_o,
    output mem_r_en_o, mem_r_addr_o, mem_w_en_o, mem_w_addr_o, mem_w_data_o
  );
endinterface

// File: rtl/cabac_mvd_row_buf.sv
// 16-entry row register file: one write port, one combinational read port, sync clear.
// Same-cycle write after clear lands, so an update arriving with the clear is kept.
module cabac_mvd_row_buf
  import cabac_mvd_top_ctrl_pkg::*;
#(
  parameter bit HAS_VALID = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       we,
  input  logic [IDX_W-1:0]           widx,
  input  logic [DATA_W-1:0]          wdat,
  input  logic [IDX_W-1:0]           ridx,
  output logic [DATA_W-1:0]          rdat,
  output logic [MVD_TOP_ENTRIES-1:0] valid
);
  logic [DATA_W-1:0]          entry [MVD_TOP_ENTRIES];
  logic [MVD_TOP_ENTRIES-1:0] vld;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < MVD_TOP_ENTRIES; i++) entry[i] <= '0;
      vld <= '0;
    end
    if (!rst && we) begin
      entry[widx] <= wdat;
      vld[widx]   <= HAS_VALID;
    end
  end

  assign rdat  = entry[ridx];
  assign valid = vld;
endmodule

// File: rtl/cabac_mvd_top_ctrl.sv
// Top-neighbour MVD sequencer: 18-cycle prefetch of 16 top entries, bottom-row collection,
// 16-slot write-back of the valid entries; protocol violations are dropped and flagged on err_o.
module cabac_mvd_top_ctrl
  import cabac_mvd_top_ctrl_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  cabac_mvd_top_ctrl_if.slave bus
);
  mvd_top_state_t      state;
  logic [IDX_W-1:0]    cnt;
  logic [LCU_X_W-1:0]  lcu_x;
  logic                cap_vld;
  logic [IDX_W-1:0]    cap_idx;
  logic                busy, prefetch_done, wb_done, err;
  logic                r_en, w_en;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [DATA_W-1:0]   w_data;

  logic                start_ok, upd_ok, top_we;
  logic [IDX_W-1:0]    slot_idx;
  logic                slot_hit, slot_vld;
  logic [DATA_W-1:0]   slot_dat, bot_rdat, top_rdat;
  logic [MVD_TOP_ENTRIES-1:0] bot_valid, top_valid_unused;

  assign start_ok = bus.lcu_start_i && (state == MVD_TOP_IDLE);
  assign upd_ok   = bus.upd_valid_i && (state != MVD_TOP_WB);
  assign top_we   = cap_vld && (state == MVD_TOP_PREFETCH);

  // Slot prepared for the next cycle; forwards an update landing in the same cycle as lcu_done.
  always_comb begin
    slot_idx = '0;
    if (state == MVD_TOP_WB) slot_idx = cnt + IDX_W'(1);
    slot_hit = upd_ok && (bus.upd_idx_i == slot_idx);
    slot_vld = bot_valid[slot_idx] || slot_hit;
    slot_dat = slot_hit ? bus.upd_data_i : bot_rdat;
  end

  cabac_mvd_row_buf #(.HAS_VALID(1'b0)) u_top_buf (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok && bus.first_row_i),
    .we    (top_we),
    .widx  (cap_idx),
    .wdat  (bus.mem_r_data_i),
    .ridx  (bus.rd_idx_i),
    .rdat  (top_rdat),
    .valid (top_valid_unused)
  );

  cabac_mvd_row_buf #(.HAS_VALID(1'b1)) u_bot_buf (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .we    (upd_ok),
    .widx  (bus.upd_idx_i),
    .wdat  (bus.upd_data_i),
    .ridx  (slot_idx),
    .rdat  (bot_rdat),
    .valid (bot_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= MVD_TOP_IDLE;
      cnt           <= '0;
      lcu_x         <= '0;
      cap_vld       <= 1'b0;
      cap_idx       <= '0;
      busy          <= 1'b0;
      prefetch_done <= 1'b0;
      wb_done       <= 1'b0;
      err           <= 1'b0;
      r_en          <= 1'b0;
      r_addr        <= '0;
      w_en          <= 1'b0;
      w_addr        <= '0;
      w_data        <= '0;
    end else begin
      prefetch_done <= 1'b0;
      wb_done       <= 1'b0;
      err           <= (bus.lcu_start_i && state != MVD_TOP_IDLE) ||
                       (bus.lcu_done_i  && state != MVD_TOP_READY) ||
                       (bus.upd_valid_i && state == MVD_TOP_WB);
      // Read data returns one cycle after the request; remember which entry it belongs to.
      cap_vld       <= r_en;
      cap_idx       <= r_addr[IDX_W-1:0];
      case (state)
        MVD_TOP_IDLE: if (bus.lcu_start_i) begin
          lcu_x <= bus.lcu_x_i;
          cnt   <= '0;
          busy  <= 1'b1;
          if (bus.first_row_i) begin
            state         <= MVD_TOP_READY;
            prefetch_done <= 1'b1;
          end else begin
            state  <= MVD_TOP_PREFETCH;
            r_en   <= 1'b1;
            r_addr <= mk_addr(bus.lcu_x_i, '0);
          end
        end
        MVD_TOP_PREFETCH: begin
          if (r_en) begin
            if (cnt == LAST_IDX) begin
              r_en   <= 1'b0;
              r_addr <= '0;
            end else begin
              cnt    <= cnt + IDX_W'(1);
              r_addr <= mk_addr(lcu_x, cnt + IDX_W'(1));
            end
          end
          if (cap_vld && cap_idx == LAST_IDX) begin
            state         <= MVD_TOP_READY;
            prefetch_done <= 1'b1;
          end
        end
        MVD_TOP_READY: if (bus.lcu_done_i) begin
          state  <= MVD_TOP_WB;
          cnt    <= '0;
          w_en   <= slot_vld;
          w_addr <= mk_addr(lcu_x, slot_idx);
          w_data <= slot_dat;
        end
        MVD_TOP_WB: begin
          if (cnt == LAST_IDX) begin
            state   <= MVD_TOP_IDLE;
            busy    <= 1'b0;
            wb_done <= 1'b1;
            w_en    <= 1'b0;
            w_addr  <= '0;
            w_data  <= '0;
          end else begin
            cnt    <= cnt + IDX_W'(1);
            w_en   <= slot_vld;
            w_addr <= mk_addr(lcu_x, slot_idx);
            w_data <= slot_dat;
          end
        end
      endcase
    end
  end

  assign bus.rd_data_o       = top_rdat;
  assign bus.prefetch_done_o = prefetch_done;
  assign bus.wb_done_o       = wb_done;
  assign bus.busy_o          = busy;
  assign bus.err_o           = err;
  assign bus.mem_r_en_o      = r_en;
  assign bus.mem_r_addr_o    = r_addr;
  assign bus.mem_w_en_o      = w_en;
  assign bus.mem_w_addr_o    = w_addr;
  assign bus.mem_w_data_o    = w_data;
endmodule

// File: tb/tb_cabac_mvd_top_ctrl.sv
// Directed bench for cabac_mvd_top_ctrl with a synchronous-read line-memory model.
module tb_cabac_mvd_top_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rd_cnt  = 0;
  int   wr_cnt  = 0;
  logic [17:0] mem [512];

  always #5 clk = ~clk;

  cabac_mvd_top_ctrl_if bus ();

  cabac_mvd_top_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) begin
    if (bus.mem_r_en_o) begin
      bus.mem_r_data_i <= mem[bus.mem_r_addr_o];
      rd_cnt++;
    end
    if (bus.mem_w_en_o) begin
      mem[bus.mem_w_addr_o] <= bus.mem_w_data_o;
      wr_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    rst = 1'b0;
    n_tests++;
    if ({bus.busy_o, bus.prefetch_done_o, bus.wb_done_o, bus.err_o, bus.mem_r_en_o, bus.mem_w_en_o} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000",
        {bus.busy_o, bus.prefetch_done_o, bus.wb_done_o, bus.err_o, bus.mem_r_en_o, bus.mem_w_en_o});
    end
    n_tests++;
    if ({bus.mem_r_addr_o, bus.mem_w_addr_o, bus.mem_w_data_o, bus.rd_data_o} !== 54'd0) begin
      n_fail++; $display("FAIL reset_buses: raddr %h waddr %h wdata %h rdata %h want 0",
        bus.mem_r_addr_o, bus.mem_w_addr_o, bus.mem_w_data_o, bus.rd_data_o);
    end
  endtask

  task automatic test_prefetch();
    bus.lcu_x_i = 5'd3; bus.first_row_i = 1'b0; bus.lcu_start_i = 1'b1;
    tick();
    bus.lcu_start_i = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      n_tests++;
      if (bus.mem_r_en_o !== 1'b1 || bus.mem_r_addr_o !== 9'(9'h030 + c - 1) || bus.prefetch_done_o !== 1'b0) begin
        n_fail++; $display("FAIL prefetch_read c%0d: en %b addr %h done %b want 1 %h 0",
          c, bus.mem_r_en_o, bus.mem_r_addr_o, bus.prefetch_done_o, 9'(9'h030 + c - 1));
      end
      tick();
    end
    n_tests++;
    if (bus.mem_r_en_o !== 1'b0 || bus.prefetch_done_o !== 1'b0) begin
      n_fail++; $display("FAIL prefetch_c17: en %b done %b want 0 0", bus.mem_r_en_o, bus.prefetch_done_o);
    end
    tick();
    n_tests++;
    if (bus.prefetch_done_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      n_fail++; $display("FAIL prefetch_done_c18: done %b busy %b want 1 1", bus.prefetch_done_o, bus.busy_o);
    end
    tick();
    n_tests++;
    if (bus.prefetch_done_o !== 1'b0) begin
      n_fail++; $display("FAIL prefetch_done_pulse: got %b want 0", bus.prefetch_done_o);
    end
    for (int i = 0; i < 16; i++) begin
      bus.rd_idx_i = 4'(i);
      #1;
      n_tests++;
      if (bus.rd_data_o !== 18'(18'h130 + i)) begin
        n_fail++; $display("FAIL prefetch_rd_idx%0d: got %h want %h", i, bus.rd_data_o, 18'(18'h130 + i));
      end
    end
    bus.rd_idx_i = 4'd5;
    #1;
    n_tests++;
    if (bus.rd_data_o !== 18'h00135) begin
      n_fail++; $display("FAIL prefetch_rd5: got %h want 00135", bus.rd_data_o);
    end
  endtask

  task automatic test_partial_wb();
    logic exp_en;
    bus.upd_valid_i = 1'b1; bus.upd_idx_i = 4'd2;  bus.upd_data_i = 18'h0AAAA; tick();
    bus.upd_idx_i = 4'd15; bus.upd_data_i = 18'h3FFFF; tick();
    bus.upd_idx_i = 4'd2;  bus.upd_data_i = 18'h01234; tick();
    bus.upd_valid_i = 1'b0; bus.lcu_done_i = 1'b1;
    tick();
    bus.lcu_done_i = 1'b0;
    for (int s = 0; s < 16; s++) begin
      exp_en = (s == 2) || (s == 15);
      n_tests++;
      if (bus.mem_w_en_o !== exp_en || bus.mem_r_en_o !== 1'b0) begin
        n_fail++; $display("FAIL wb_slot%0d_en: wen %b ren %b want %b 0", s, bus.mem_w_en_o, bus.mem_r_en_o, exp_en);
      end
      if (exp_en) begin
        n_tests++;
        if (bus.mem_w_addr_o !== 9'(9'h030 + s) || bus.mem_w_data_o !== (s == 2 ? 18'h01234 : 18'h3FFFF)) begin
          n_fail++; $display("FAIL wb_slot%0d_data: addr %h data %h", s, bus.mem_w_addr_o, bus.mem_w_data_o);
        end
      end
      tick();
    end
    n_tests++;
    if (bus.wb_done_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.mem_w_en_o !== 1'b0) begin
      n_fail++; $display("FAIL wb_done_t17: done %b busy %b wen %b want 1 0 0", bus.wb_done_o, bus.busy_o, bus.mem_w_en_o);
    end
    n_tests++;
    if (mem[9'h032] !== 18'h01234 || mem[9'h03F] !== 18'h3FFFF || mem[9'h033] !== 18'h00133) begin
      n_fail++; $display("FAIL wb_memory: m32 %h m3F %h m33 %h want 01234 3FFFF 00133",
        mem[9'h032], mem[9'h03F], mem[9'h033]);
    end
  endtask

  task automatic test_first_row();
    int rd0;
    rd0 = rd_cnt;
    bus.lcu_x_i = 5'd5; bus.first_row_i = 1'b1; bus.lcu_start_i = 1'b1;
    tick();
    bus.lcu_start_i = 1'b0; bus.first_row_i = 1'b0;
    n_tests++;
    if (bus.prefetch_done_o !== 1'b1 || bus.mem_r_en_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      n_fail++; $display("FAIL first_row_c1: done %b ren %b busy %b want 1 0 1", bus.prefetch_done_o, bus.mem_r_en_o, bus.busy_o);
    end
    for (int i = 0; i < 16; i++) begin
      bus.rd_idx_i = 4'(i);
      #1;
      n_tests++;
      if (bus.rd_data_o !== 18'h0) begin
        n_fail++; $display("FAIL first_row_rd%0d: got %h want 00000", i, bus.rd_data_o);
      end
    end
    tick();
    n_tests++;
    if (rd_cnt !== rd0) begin
      n_fail++; $display("FAIL first_row_reads: got %0d want %0d", rd_cnt - rd0, 0);
    end
  endtask

  task automatic test_upd_with_done();
    int wr0;
    bus.upd_valid_i = 1'b1; bus.upd_idx_i = 4'd0; bus.upd_data_i = 18'h2BEEF; bus.lcu_done_i = 1'b1;
    tick();
    bus.lcu_done_i = 1'b0;
    wr0 = wr_cnt;
    n_tests++;
    if (bus.mem_w_en_o !== 1'b1 || bus.mem_w_addr_o !== 9'h050 || bus.mem_w_data_o !== 18'h2BEEF || bus.err_o !== 1'b0) begin
      n_fail++; $display("FAIL coincident_write: en %b addr %h data %h err %b want 1 050 2BEEF 0",
        bus.mem_w_en_o, bus.mem_w_addr_o, bus.mem_w_data_o, bus.err_o);
    end
    bus.upd_idx_i = 4'd9; bus.upd_data_i = 18'h15555;
    tick();
    bus.upd_valid_i = 1'b0;
    n_tests++;
    if (bus.err_o !== 1'b1) begin
      n_fail++; $display("FAIL upd_in_wb_err: got %b want 1", bus.err_o);
    end
    for (int s = 1; s < 16; s++) begin
      n_tests++;
      if (bus.mem_w_en_o !== 1'b0) begin
        n_fail++; $display("FAIL upd_in_wb_slot%0d: wen %b want 0", s, bus.mem_w_en_o);
      end
      tick();
    end
    n_tests++;
    if (bus.wb_done_o !== 1'b1 || wr_cnt - wr0 !== 1) begin
      n_fail++; $display("FAIL upd_in_wb_done: done %b writes %0d want 1 1", bus.wb_done_o, wr_cnt - wr0);
    end
  endtask

  task automatic test_protocol_err();
    int wr0;
    bus.lcu_x_i = 5'd1; bus.lcu_start_i = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      bus.lcu_start_i = (c == 3);
      bus.lcu_x_i     = (c == 3) ? 5'd9 : 5'd1;
      bus.lcu_done_i  = (c == 5);
      n_tests++;
      if (bus.mem_r_en_o !== 1'b1 || bus.mem_r_addr_o !== 9'(9'h010 + c - 1) ||
          bus.err_o !== ((c == 4) || (c == 6))) begin
        n_fail++; $display("FAIL err_prefetch c%0d: en %b addr %h err %b", c, bus.mem_r_en_o, bus.mem_r_addr_o, bus.err_o);
      end
      tick();
    end
    bus.lcu_start_i = 1'b0; bus.lcu_done_i = 1'b0;
    tick();
    bus.rd_idx_i = 4'd15;
    #1;
    n_tests++;
    if (bus.prefetch_done_o !== 1'b1 || bus.rd_data_o !== 18'h0011F) begin
      n_fail++; $display("FAIL err_prefetch_result: done %b rd %h want 1 0011F", bus.prefetch_done_o, bus.rd_data_o);
    end
    wr0 = wr_cnt;
    bus.lcu_done_i = 1'b1; tick(); bus.lcu_done_i = 1'b0;
    repeat (16) tick();
    n_tests++;
    if (bus.wb_done_o !== 1'b1 || wr_cnt !== wr0) begin
      n_fail++; $display("FAIL err_empty_wb: done %b writes %0d want 1 0", bus.wb_done_o, wr_cnt - wr0);
    end
    bus.lcu_done_i = 1'b1; tick(); bus.lcu_done_i = 1'b0;
    n_tests++;
    if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL done_in_idle: err %b busy %b want 1 0", bus.err_o, bus.busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int rd0;
    bus.lcu_x_i = 5'd2; bus.lcu_start_i = 1'b1;
    tick();
    bus.lcu_start_i = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd0 = rd_cnt;
    n_tests++;
    if ({bus.busy_o, bus.mem_r_en_o, bus.mem_w_en_o, bus.prefetch_done_o, bus.err_o} !== 5'b0 ||
        bus.mem_r_addr_o !== 9'h0 || bus.rd_data_o !== 18'h0) begin
      n_fail++; $display("FAIL reset_mid_outputs: busy %b ren %b wen %b raddr %h rd %h want all 0",
        bus.busy_o, bus.mem_r_en_o, bus.mem_w_en_o, bus.mem_r_addr_o, bus.rd_data_o);
    end
    repeat (20) tick();
    n_tests++;
    if (rd_cnt !== rd0 || bus.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_quiet: reads %0d busy %b want 0 0", rd_cnt - rd0, bus.busy_o);
    end
    bus.lcu_start_i = 1'b1; tick(); bus.lcu_start_i = 1'b0;
    repeat (17) tick();
    bus.rd_idx_i = 4'd7;
    #1;
    n_tests++;
    if (bus.prefetch_done_o !== 1'b1 || bus.rd_data_o !== 18'h00127 || rd_cnt - rd0 !== 16) begin
      n_fail++; $display("FAIL reset_mid_restart: done %b rd %h reads %0d want 1 00127 16",
        bus.prefetch_done_o, bus.rd_data_o, rd_cnt - rd0);
    end
  endtask

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = 18'(256 + a);
    bus.lcu_start_i = 1'b0; bus.lcu_x_i = '0; bus.first_row_i = 1'b0; bus.lcu_done_i = 1'b0;
    bus.rd_idx_i = '0; bus.upd_valid_i = 1'b0; bus.upd_idx_i = '0; bus.upd_data_i = '0;
    bus.mem_r_data_i = '0;
    test_reset();
    test_prefetch();
    test_partial_wb();
    test_first_row();
    test_upd_with_done();
    test_protocol_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cabac_mvd_top_ctrl.md
# cabac_mvd_top_ctrl

Sequencer for the CABAC top-neighbour MVD line memory (2-port RF, 18-bit words, 9-bit address). When an LCU starts, it prefetches the LCU's 16 top-row MVD entries into a local register buffer for the context-selection logic. During the LCU it collects bottom-row MVD updates. When the LCU finishes, it writes those updates back to the memory. It sits between the CABAC syntax/context logic and the `cabac_mvd_top_2p_*` memory instance.

## Interface
- `ADDR_W`, 9: memory address width; address = {lcu_x, idx}.
- `DATA_W`, 18: word width, 2*(`FMV_WIDTH`+1), packed {mvd_y_top, mvd_x_top}.
- `IDX_W`, 4: entry index width; 16 entries (4x4 columns) per LCU.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `lcu_start_i`  in  1  one-cycle pulse: new LCU begins.
- `lcu_x_i`  in  ADDR_W-IDX_W  LCU column, sampled with `lcu_start_i`.
- `first_row_i`  in  1  top row unavailable, sampled with `lcu_start_i`.
- `lcu_done_i`  in  1  one-cycle pulse: LCU syntax finished.
- `rd_idx_i`  in  IDX_W  top entry select.
- `rd_data_o`  out  DATA_W  top entry, combinational from the local buffer.
- `upd_valid_i`  in  1  bottom-row update strobe.
- `upd_idx_i`  in  IDX_W  update index.
- `upd_data_i`  in  DATA_W  update data.
- `prefetch_done_o`  out  1  one-cycle pulse: top buffer valid.
- `wb_done_o`  out  1  one-cycle pulse: write-back complete.
- `busy_o`  out  1  state != IDLE.
- `err_o`  out  1  one-cycle pulse: protocol violation.
- `mem_r_en_o`  out  1  memory read enable (active-high).
- `mem_r_addr_o`  out  ADDR_W  memory read address.
- `mem_r_data_i`  in  DATA_W  memory read data, valid one cycle after read enable.
- `mem_w_en_o`  out  1  memory write enable (active-high).
- `mem_w_addr_o`  out  ADDR_W  memory write address.
- `mem_w_data_o`  out  DATA_W  memory write data.

## Operation
- **FSM states:** IDLE, PREFETCH, READY, WRITEBACK.
- **IDLE + `lcu_start_i`:**
  - Latch `lcu_x`.
  - Clear all 16 update-valid bits.
  - If `first_row_i`=1: clear the top buffer to 0 and go to READY.
  - Otherwise: go to PREFETCH with cnt=0.
- **PREFETCH:**
  - Issue reads with `mem_r_en_o`=1 and address {lcu_x, cnt}, cnt 0..15.
  - Capture `mem_r_data_i` into `top_buf[cnt_d1]` one cycle after each read.
  - After the last capture, go to READY and pulse `prefetch_done_o`.
- **READY + `lcu_done_i`:** go to WRITEBACK with cnt=0.
- **Bottom-row updates:**
  - Accepted in any state except WRITEBACK.
  - Action: `bot_buf[upd_idx_i]` <= `upd_data_i` and set `valid[upd_idx_i]`.
  - A repeated index overwrites the earlier value.
- **WRITEBACK:**
  - For cnt 0..15: `mem_w_addr_o`={lcu_x, cnt}, `mem_w_data_o`=`bot_buf[cnt]`, `mem_w_en_o`=`valid[cnt]`.
  - Entries without a valid bit are skipped, so the memory keeps its old value.
  - Then go to IDLE and pulse `wb_done_o`.
- **Simultaneous events:**
  - `upd_valid_i` in the same cycle as `lcu_done_i`: the update is accepted and written back.
  - `upd_valid_i` during WRITEBACK: ignored, `err_o` pulses.
- **Protocol errors:**
  - `lcu_start_i` outside IDLE: ignored, `err_o` pulses.
  - `lcu_done_i` outside READY: ignored, `err_o` pulses.
- **`rd_data_o` validity:** always equals `top_buf[rd_idx_i]`, but is only meaningful from the `prefetch_done_o` cycle until the next `lcu_start_i`.
- **Port independence:** the read and write ports are never active in the same cycle, so there is no same-address hazard inside the block.

## Timing
- **Reset values:**
  - All outputs 0, state IDLE.
  - `top_buf`, `bot_buf` and `valid` cleared.
  - `rst` in any state aborts: no further memory accesses occur.
- **Prefetch, `lcu_start_i` in cycle 0:**
  - Cycles 1..16: `mem_r_en_o`=1, addresses base+0..base+15.
  - Cycles 2..17: data captured.
  - Cycle 18: READY and `prefetch_done_o`=1.
  - Latency is 18 cycles.
- **First row:** READY and `prefetch_done_o` in cycle 1; no memory reads.
- **Write-back, `lcu_done_i` in cycle t:**
  - Cycles t+1..t+16: write slots.
  - Cycle t+17: IDLE and `wb_done_o`=1.
  - A new `lcu_start_i` is accepted from cycle t+17.
- **Register/combinational split:**
  - `mem_*` outputs and the done/err pulses are registered.
  - `rd_data_o` is combinational.
- **Address formation:** `lcu_x` concatenated with cnt; no carry. Wrap-around of cnt ends the phase.

## Structure
- **Shared package / `enc_defines.v`:**
  - `FMV_WIDTH`.
  - State encodings `MVD_TOP_IDLE`/`PREFETCH`/`READY`/`WB`.
  - `MVD_TOP_ENTRIES`=16.
- **Sub-module:** one, `cabac_mvd_row_buf`. It is a 16x`DATA_W` register file with a valid-bit vector, one write port, one combinational read port and a synchronous clear. The block instantiates it twice: top buffer without valid bits, bottom buffer with valid bits.
- **Top level:** FSM, counter, capture pipeline flag and memory-port muxing.

## Test plan
- **Normal prefetch:** memory model preloaded with word (0x100+a) at address a; `lcu_start_i` with `lcu_x`=3 -> reads at 0x30..0x3F in cycles 1..16, `prefetch_done_o` in cycle 18, and `rd_idx_i`=5 returns 0x135.
- **First row:** `lcu_start_i` with `first_row_i`=1 -> no `mem_r_en_o`, `prefetch_done_o` in cycle 1, all `rd_data_o`=0.
- **Partial write-back:** updates at idx 2 (0x0AAAA) and 15 (0x3FFFF), idx 2 rewritten with 0x01234, then `lcu_done_i` -> exactly two writes: {lcu_x,2}=0x01234 and {lcu_x,15}=0x3FFFF; `wb_done_o` at t+17.
- **Update coincident with done:** `upd_valid_i` idx 0 in the same cycle as `lcu_done_i` -> a write to {lcu_x,0} occurs in cycle t+1.
- **Protocol errors:**
  - `lcu_start_i` in PREFETCH -> `err_o` pulses, state and addresses unaffected.
  - `upd_valid_i` in WRITEBACK -> `err_o` pulses, no extra write.
- **Reset mid-operation:** `rst` in prefetch cycle 8 -> next cycle IDLE, all outputs 0, no memory activity; a subsequent `lcu_start_i` runs a full prefetch.
